// File: rtl/upsp_outbuf_pack.sv
// rtl/upsp_outbuf_pack.sv - packs edge-trimmed N_PIX write beats into a circular pixel buffer
// and drains it as fixed OUT_PIX beats with row/frame markers.
module upsp_outbuf_pack #(
  parameter int PIX_WIDTH      = 24,
  parameter int N_PIX          = 4,
  parameter int EDGE_PIX       = 2,
  parameter int OUT_PIX        = 4,
  parameter int DEPTH          = 64,
  parameter int DST_IMG_WIDTH  = 4096,
  parameter int DST_IMG_HEIGHT = 2160
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  input  logic [N_PIX*PIX_WIDTH-1:0]     s_data,
  output logic                           s_ready,
  output logic                           m_valid,
  output logic [OUT_PIX*PIX_WIDTH-1:0]   m_data,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           m_user,
  output logic                           frame_done,
  output logic [$clog2(DEPTH):0]         fill
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DST_IMG_WIDTH + 1);
  localparam int RW   = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int KEEP = N_PIX - EDGE_PIX;

  localparam logic [CW-1:0] LAST_WCOL = CW'(DST_IMG_WIDTH - KEEP);
  localparam logic [CW-1:0] LAST_OCOL = CW'(DST_IMG_WIDTH - OUT_PIX);
  localparam logic [CW-1:0] ROW_W     = CW'(DST_IMG_WIDTH);
  localparam logic [RW-1:0] LAST_ROW  = RW'(DST_IMG_HEIGHT - 1);
  localparam logic [AW:0]   DEPTH_F   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   N_F       = (AW+1)'(N_PIX);
  localparam logic [AW:0]   KEEP_F    = (AW+1)'(KEEP);
  localparam logic [AW:0]   OUT_F     = (AW+1)'(OUT_PIX);

  logic [PIX_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          fill_q, fill_d;
  logic [CW-1:0]        wcol_q, ocol_q, wcol_sum;
  logic [RW-1:0]        orow_q;
  logic                 s_ready_q, frame_done_q;
  logic                 wr_en, rd_en, first_w, last_w;
  logic [AW:0]          wnum;
  logic [PIX_WIDTH-1:0] lane_pix [N_PIX];

  always_comb begin
    first_w  = (wcol_q == '0);
    last_w   = (wcol_q == LAST_WCOL);
    wnum     = (first_w || last_w) ? KEEP_F : N_F;
    wr_en    = s_valid & s_ready_q;
    rd_en    = m_valid & m_ready;
    fill_d   = fill_q + (wr_en ? wnum : '0) - (rd_en ? OUT_F : '0);
    wcol_sum = wcol_q + CW'(wnum);
  end

  // On the closing write of a row the kept pixels sit in the upper lanes; shift them down.
  always_comb begin
    for (int k = 0; k < N_PIX; k++) begin
      int idx;
      idx = (last_w && k < KEEP) ? k + EDGE_PIX : k;
      lane_pix[k] = s_data[idx*PIX_WIDTH +: PIX_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N_PIX; k++) begin
        if (k < int'(wnum)) mem_q[wptr_q + AW'(k)] <= lane_pix[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fill_q       <= '0;
      wcol_q       <= '0;
      ocol_q       <= '0;
      orow_q       <= '0;
      s_ready_q    <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      s_ready_q    <= (DEPTH_F - fill_d) >= N_F;
      frame_done_q <= 1'b0;
      if (wr_en) begin
        wptr_q <= wptr_q + wnum[AW-1:0];
        wcol_q <= (wcol_sum == ROW_W) ? '0 : wcol_sum;
      end
      if (rd_en) begin
        rptr_q <= rptr_q + AW'(OUT_PIX);
        if (ocol_q == LAST_OCOL) begin
          ocol_q <= '0;
          if (orow_q == LAST_ROW) begin
            orow_q       <= '0;
            frame_done_q <= 1'b1;
          end else begin
            orow_q <= orow_q + 1'b1;
          end
        end else begin
          ocol_q <= ocol_q + CW'(OUT_PIX);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < OUT_PIX; k++) begin
      m_data[k*PIX_WIDTH +: PIX_WIDTH] = mem_q[rptr_q + AW'(k)];
    end
  end

  assign s_ready    = s_ready_q;
  assign fill       = fill_q;
  assign m_valid    = (fill_q >= OUT_F);
  assign m_last     = m_valid && (ocol_q == LAST_OCOL);
  assign m_user     = m_valid && (ocol_q == '0) && (orow_q == '0);
  assign frame_done = frame_done_q;

endmodule
